// File: rtl/mult_pkg.sv
// Shared key codes, controller state encoding and key classification
// for the operand entry path in front of the signed multiplier.
package mult_pkg;

    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        START,
        WAIT,
        DONE
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/operand_entry_ctrl_if.sv
// Keypad, multiplier and display signals of the operand entry controller.
// The master side is the controller; the slave side is its environment.
interface operand_entry_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic             mult_ready;
    logic [WIDTH-1:0] num_1;
    logic [WIDTH-1:0] num_2;
    logic             mult_valid;
    logic             busy;
    logic [WIDTH-1:0] entry_value;
    logic             entry_sign;
    logic             entry_sel;
    logic             key_err;

    modport master (
        input  key_valid, key_code, mult_ready,
        output num_1, num_2, mult_valid, busy,
               entry_value, entry_sign, entry_sel, key_err
    );

    modport slave (
        output key_valid, key_code, mult_ready,
        input  num_1, num_2, mult_valid, busy,
               entry_value, entry_sign, entry_sel, key_err
    );
endinterface

// File: rtl/dec_accum.sv
// Decimal accumulator for one operand: magnitude, digit count and sign,
// with range and digit-count rejection of incoming digits.
module dec_accum #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             digit_stb,
    input  logic [3:0]       digit,
    input  logic             toggle_stb,
    input  logic             clear_stb,
    output logic [WIDTH-1:0] accum,
    output logic             sign,
    output logic             reject
);
    localparam int XW = WIDTH + 4;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [XW-1:0] MAX_MAG = XW'((2 ** (WIDTH - 1)) - 1);

    logic [CW-1:0] count_reg;
    logic [XW-1:0] cand;
    logic          lead_zero;
    logic          digit_ok;

    // Extra 4 bits keep accum*10+d from wrapping before the range test.
    assign cand      = ({4'b0000, accum} * XW'(10)) + XW'(digit);
    assign lead_zero = (digit == 4'd0) && (accum == '0);
    assign digit_ok  = lead_zero ||
                       ((count_reg != CW'(MAX_DIGITS)) && (cand <= MAX_MAG));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accum     <= '0;
            sign      <= 1'b0;
            count_reg <= '0;
            reject    <= 1'b0;
        end else begin
            reject <= 1'b0;
            if (clear_stb) begin
                accum     <= '0;
                sign      <= 1'b0;
                count_reg <= '0;
            end else if (digit_stb) begin
                if (digit_ok) begin
                    accum <= cand[WIDTH-1:0];
                    if (!lead_zero) count_reg <= count_reg + CW'(1);
                end else begin
                    reject <= 1'b1;
                end
            end else if (toggle_stb) begin
                sign <= ~sign;
            end
        end
    end
endmodule

// File: rtl/operand_entry_ctrl.sv
// Sequencer collecting two signed decimal operands from the keypad and
// handing them to the multiplier with a one-cycle start pulse.
module operand_entry_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    operand_entry_ctrl_if.master bus
);
    entry_state_t     state_reg, state_next;
    logic [WIDTH-1:0] num_1_reg, num_2_reg;
    logic [WIDTH-1:0] accum, commit;
    logic             sign, dec_reject;
    logic             pend_reg, pend_set, pend_clr;
    logic             key_err_reg, err_set;
    logic             digit_stb, toggle_stb, clear_stb, load_1, load_2;
    logic             key_clear;

    dec_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_accum (
        .clk       (clk),
        .reset     (reset),
        .digit_stb (digit_stb),
        .digit     (bus.key_code),
        .toggle_stb(toggle_stb),
        .clear_stb (clear_stb),
        .accum     (accum),
        .sign      (sign),
        .reject    (dec_reject)
    );

    // Negative zero naturally commits as 0.
    assign commit    = sign ? (~accum + WIDTH'(1)) : accum;
    assign key_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);

    always_comb begin
        state_next = state_reg;
        digit_stb  = 1'b0;
        toggle_stb = 1'b0;
        clear_stb  = 1'b0;
        load_1     = 1'b0;
        load_2     = 1'b0;
        err_set    = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        unique case (state_reg)
            ENTER_A, ENTER_B: begin
                if (bus.key_valid) begin
                    if (is_digit(bus.key_code)) begin
                        digit_stb = 1'b1;
                    end else if (bus.key_code == KEY_SIGN) begin
                        toggle_stb = 1'b1;
                    end else if (bus.key_code == KEY_ENTER) begin
                        clear_stb = 1'b1;
                        if (state_reg == ENTER_A) begin
                            load_1     = 1'b1;
                            state_next = ENTER_B;
                        end else begin
                            load_2     = 1'b1;
                            state_next = START;
                        end
                    end else if (bus.key_code == KEY_CLEAR) begin
                        clear_stb  = 1'b1;
                        state_next = ENTER_A;
                    end
                end
            end
            START: begin
                pend_set   = key_clear;
                state_next = WAIT;
            end
            WAIT: begin
                // A clear arriving with mult_ready still counts as pending.
                pend_set = key_clear;
                if (bus.mult_ready) begin
                    pend_clr   = 1'b1;
                    state_next = (pend_reg || key_clear) ? ENTER_A : DONE;
                end
            end
            DONE: begin
                if (bus.key_valid) begin
                    if (is_digit(bus.key_code)) begin
                        digit_stb  = 1'b1;
                        state_next = ENTER_A;
                    end else if (bus.key_code == KEY_SIGN || bus.key_code == KEY_ENTER) begin
                        err_set = 1'b1;
                    end else if (bus.key_code == KEY_CLEAR) begin
                        clear_stb  = 1'b1;
                        state_next = ENTER_A;
                    end
                end
            end
            default: state_next = ENTER_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ENTER_A;
            num_1_reg   <= '0;
            num_2_reg   <= '0;
            pend_reg    <= 1'b0;
            key_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            key_err_reg <= err_set;
            if (load_1) num_1_reg <= commit;
            if (load_2) num_2_reg <= commit;
            if (pend_clr)      pend_reg <= 1'b0;
            else if (pend_set) pend_reg <= 1'b1;
        end
    end

    assign bus.num_1       = num_1_reg;
    assign bus.num_2       = num_2_reg;
    assign bus.mult_valid  = (state_reg == START);
    assign bus.busy        = (state_reg == START) || (state_reg == WAIT);
    assign bus.entry_value = accum;
    assign bus.entry_sign  = sign;
    assign bus.entry_sel   = (state_reg == ENTER_B);
    assign bus.key_err     = key_err_reg | dec_reject;
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed and randomised checks of operand_entry_ctrl; expected operand
// pairs are queued when typed and compared when mult_valid appears.
module tb_operand_entry_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   mv_count = 0;
    int   pushes = 0;
    logic [15:0] exp_q[$];
    logic prev_mv = 1'b0;
    logic prev_busy = 1'b0;
    logic [7:0] held_1 = '0;
    logic [7:0] held_2 = '0;

    operand_entry_ctrl_if #(.WIDTH(8)) bus ();

    operand_entry_ctrl #(.WIDTH(8), .MAX_DIGITS(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        $display("key %h -> entry_value=%0d sign=%0b sel=%0b err=%0b busy=%0b",
                 code, bus.entry_value, bus.entry_sign, bus.entry_sel, bus.key_err, bus.busy);
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        bus.mult_ready = 1'b1;
        @(negedge clk);
        bus.mult_ready = 1'b0;
        $display("mult_ready -> busy=%0b sel=%0b", bus.busy, bus.entry_sel);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic type_num(input int v);
        int m;
        m = (v < 0) ? -v : v;
        if (v < 0) press(4'hA);
        if (m >= 100) press(4'(m / 100));
        if (m >= 10)  press(4'((m / 10) % 10));
        press(4'(m % 10));
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        exp_q.push_back({a, b});
        pushes = pushes + 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_num_1"}, bus.num_1, 0);
        check({tag, "_num_2"}, bus.num_2, 0);
        check({tag, "_mult_valid"}, bus.mult_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_entry_value"}, bus.entry_value, 0);
        check({tag, "_entry_sign"}, bus.entry_sign, 0);
        check({tag, "_entry_sel"}, bus.entry_sel, 0);
        check({tag, "_key_err"}, bus.key_err, 0);
    endtask

    // Scoreboard and invariants on the multiplier side.
    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            prev_mv   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (bus.mult_valid) begin
                mv_count = mv_count + 1;
                check("mv_busy", bus.busy, 1);
                check("mv_one_cycle", prev_mv, 0);
                if (exp_q.size() == 0) begin
                    check("mv_expected", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_num_1", bus.num_1, e[15:8]);
                    check("sb_num_2", bus.num_2, e[7:0]);
                    $display("mult_valid num_1=%h num_2=%h", bus.num_1, bus.num_2);
                end
            end
            if (bus.busy && prev_busy) begin
                check("num_1_stable", bus.num_1, held_1);
                check("num_2_stable", bus.num_2, held_2);
            end
            held_1    = bus.num_1;
            held_2    = bus.num_2;
            prev_busy = bus.busy;
            prev_mv   = bus.mult_valid;
        end
    end

    initial begin
        int a, b, mv_before, n;
        logic [3:0] junk;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        bus.mult_ready = 1'b0;
        idle(2);
        check_all_zero("reset");
        reset = 1'b0;
        idle(1);

        // 12, -5
        press(4'h1); press(4'h2);
        check("typing_12", bus.entry_value, 12);
        check("sel_a", bus.entry_sel, 0);
        press(4'hB);
        check("sel_b", bus.entry_sel, 1);
        check("accum_cleared", bus.entry_value, 0);
        check("num_1_12", bus.num_1, 8'h0C);
        press(4'hA);
        check("sign_neg", bus.entry_sign, 1);
        press(4'h5);
        push_pair(8'h0C, 8'hFB);
        press(4'hB);
        check("start_mv", bus.mult_valid, 1);
        check("start_busy", bus.busy, 1);
        idle(1);
        check("wait_mv_low", bus.mult_valid, 0);
        check("wait_busy", bus.busy, 1);

        // Keys ignored in WAIT
        press(4'h7);
        check("wait_digit_ignored", bus.entry_value, 0);
        check("wait_no_err", bus.key_err, 0);
        press(4'hB);
        check("wait_enter_ignored", bus.busy, 1);
        check("wait_mv_still_low", bus.mult_valid, 0);

        pulse_ready();
        check("done_busy", bus.busy, 0);
        press(4'hA);
        check("done_sign_err", bus.key_err, 1);
        check("done_sign_unchanged", bus.entry_sign, 0);
        press(4'h3);
        check("done_digit_value", bus.entry_value, 3);
        check("done_digit_sel", bus.entry_sel, 0);
        check("held_num_1", bus.num_1, 8'h0C);
        check("held_num_2", bus.num_2, 8'hFB);
        press(4'hC);
        check("clear_value", bus.entry_value, 0);

        // Range and digit-count limits
        press(4'h1); press(4'h2); press(4'h8);
        check("overflow_128_err", bus.key_err, 1);
        check("overflow_128_value", bus.entry_value, 12);
        idle(1);
        check("err_one_cycle", bus.key_err, 0);
        press(4'hC);
        press(4'h1); press(4'h2); press(4'h7);
        check("value_127", bus.entry_value, 127);
        check("value_127_no_err", bus.key_err, 0);
        press(4'hC);
        press(4'h0); press(4'h0); press(4'h0); press(4'h0);
        check("lead_zero_no_err", bus.key_err, 0);
        press(4'h4);
        check("lead_zero_value", bus.entry_value, 4);
        check("lead_zero_4_no_err", bus.key_err, 0);
        press(4'hC);
        press(4'h1); press(4'h0); press(4'h0); press(4'h0);
        check("max_digits_err", bus.key_err, 1);
        check("max_digits_value", bus.entry_value, 100);
        press(4'hC);

        // Double toggle and negative zero
        press(4'hA); press(4'hA); press(4'h9); press(4'hB);
        check("double_sign_num_1", bus.num_1, 8'h09);
        press(4'hC);
        press(4'hA); press(4'hB);
        check("neg_zero_num_1", bus.num_1, 8'h00);
        check("neg_zero_sel", bus.entry_sel, 1);

        // mult_ready outside WAIT has no effect
        pulse_ready();
        check("ready_in_b_sel", bus.entry_sel, 1);
        check("ready_in_b_busy", bus.busy, 0);

        // Clear while waiting returns to ENTER_A rather than DONE
        press(4'h5);
        push_pair(8'h00, 8'h05);
        press(4'hB);
        idle(1);
        press(4'hC);
        check("pending_busy", bus.busy, 1);
        pulse_ready();
        check("pending_busy_low", bus.busy, 0);
        press(4'hA);
        check("pending_enter_a_no_err", bus.key_err, 0);
        check("pending_enter_a_sign", bus.entry_sign, 1);
        press(4'hC);

        // Key in the same cycle as mult_ready is dropped
        press(4'h2); press(4'hB); press(4'h3);
        push_pair(8'h02, 8'h03);
        press(4'hB);
        idle(1);
        @(negedge clk);
        bus.key_valid = 1'b1; bus.key_code = 4'h4; bus.mult_ready = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0; bus.mult_ready = 1'b0;
        check("simul_busy", bus.busy, 0);
        check("simul_key_dropped", bus.entry_value, 0);
        press(4'hB);
        check("simul_done_err", bus.key_err, 1);
        press(4'hC);

        // Asynchronous reset during WAIT
        press(4'h1); press(4'hB); press(4'h1);
        push_pair(8'h01, 8'h01);
        press(4'hB);
        idle(2);
        check("pre_reset_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        mv_before = mv_count;
        press(4'h2); press(4'hB); press(4'h3);
        push_pair(8'h02, 8'h03);
        press(4'hB);
        idle(3);
        check("post_reset_one_mv", mv_count - mv_before, 1);
        check("post_reset_num_1", bus.num_1, 8'h02);
        check("post_reset_num_2", bus.num_2, 8'h03);
        pulse_ready();

        // Random operand pairs with junk keys while the multiply runs
        for (int it = 0; it < 20; it++) begin
            a = $urandom_range(0, 254) - 127;
            b = $urandom_range(0, 254) - 127;
            press(4'hC);
            type_num(a);
            press(4'hB);
            type_num(b);
            push_pair(a[7:0], b[7:0]);
            press(4'hB);
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                junk = 4'($urandom_range(0, 15));
                if (junk == 4'hC) junk = 4'hD;
                press(junk);
            end
            check("rand_busy", bus.busy, 1);
            pulse_ready();
            check("rand_num_1", bus.num_1, a[7:0]);
            check("rand_num_2", bus.num_2, b[7:0]);
        end
        idle(2);
        check("queue_empty", exp_q.size(), 0);
        check("mv_total", mv_count, pushes);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
